// File: rtl/load_unit_if.sv
// Request, response and memory-port signals of the load unit.
// The unit binds to the slave modport; the requester/memory side uses master.
interface load_unit_if #(
  parameter int MP_DATA_WIDTH = 32,
  parameter int MP_ADDR_WIDTH = 32
);
  logic                     ivalid;
  logic                     oready;
  logic [MP_ADDR_WIDTH-1:0] iaddr;
  logic [2:0]               ifunct3;
  logic                     ovalid;
  logic                     iready;
  logic [MP_DATA_WIDTH-1:0] ordata;
  logic                     oerr;
  logic                     omem_req;
  logic [MP_ADDR_WIDTH-1:0] omem_addr;
  logic                     imem_gnt;
  logic                     imem_rvalid;
  logic [MP_DATA_WIDTH-1:0] imem_rdata;

  modport slave (
    input  ivalid, iaddr, ifunct3, iready, imem_gnt, imem_rvalid, imem_rdata,
    output oready, ovalid, ordata, oerr, omem_req, omem_addr
  );

  modport master (
    output ivalid, iaddr, ifunct3, iready, imem_gnt, imem_rvalid, imem_rdata,
    input  oready, ovalid, ordata, oerr, omem_req, omem_addr
  );
endinterface

// File: rtl/load_unit.sv
// RISC-V style load unit: one request at a time, word-aligned memory reads,
// optional two-access handling of misaligned loads, sign/zero extension.
module load_unit #(
  parameter int MP_DATA_WIDTH  = 32,
  parameter int MP_ADDR_WIDTH  = 32,
  parameter bit MP_MISALIGN_EN = 1'b1
) (
  input  logic       iclk,
  input  logic       irst,
  load_unit_if.slave bus
);
  localparam int DW   = MP_DATA_WIDTH;
  localparam int AW   = MP_ADDR_WIDTH;
  localparam int N    = DW / 8;
  localparam int OFFW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_RD0, S_RD1, S_RESP} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic [AW-1:0]   maddr_q, maddr_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [2:0]      f3_q, f3_d;
  logic            mis_q, mis_d;
  logic [DW-1:0]   lo_q, lo_d;
  logic [DW-1:0]   data_q, data_d;
  logic            err_q, err_d;
  logic            vld_q, vld_d;

  logic [OFFW-1:0] req_off;
  logic            req_illegal;
  logic            req_mis;
  logic [DW-1:0]   fit_shifted;
  logic [2*DW-1:0] pair_shifted;

  // Narrow loads are left-justified then shifted back, arithmetically for signed.
  function automatic logic [DW-1:0] extend_load(input logic [DW-1:0] raw,
                                                input logic [2:0]    f3);
    int                    sh;
    logic signed [DW-1:0]  s;
    sh = DW - (8 << int'(f3[1:0]));
    if (sh < 0) sh = 0;
    if (f3[2]) return (raw << sh) >> sh;
    s = $signed(raw << sh);
    s = s >>> sh;
    return $unsigned(s);
  endfunction

  always_comb begin
    req_off     = bus.iaddr[OFFW-1:0];
    req_illegal = (bus.ifunct3 == 3'b111) ||
                  ((DW == 32) && ((bus.ifunct3 == 3'b011) || (bus.ifunct3 == 3'b110)));
    req_mis     = (int'(req_off) + (1 << int'(bus.ifunct3[1:0]))) > N;
  end

  assign fit_shifted  = bus.imem_rdata >> {off_q, 3'b000};
  assign pair_shifted = {bus.imem_rdata, lo_q} >> {off_q, 3'b000};

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    maddr_d = maddr_q;
    off_d   = off_q;
    f3_d    = f3_q;
    mis_d   = mis_q;
    lo_d    = lo_q;
    data_d  = data_q;
    err_d   = err_q;
    vld_d   = vld_q;
    case (state_q)
      S_IDLE: begin
        if (bus.ivalid) begin
          off_d   = req_off;
          f3_d    = bus.ifunct3;
          mis_d   = req_mis;
          maddr_d = {bus.iaddr[AW-1:OFFW], {OFFW{1'b0}}};
          if (req_illegal || (req_mis && !MP_MISALIGN_EN)) begin
            state_d = S_RESP;
            vld_d   = 1'b1;
            err_d   = 1'b1;
            data_d  = '0;
          end else begin
            state_d = S_RD0;
            req_d   = 1'b1;
            err_d   = 1'b0;
          end
        end
      end
      S_RD0: begin
        if (req_q) begin
          if (bus.imem_gnt) req_d = 1'b0;
        end else if (bus.imem_rvalid) begin
          if (mis_q) begin
            // Low half kept; the high half comes from the next word (address wraps).
            lo_d    = bus.imem_rdata;
            maddr_d = maddr_q + AW'(N);
            req_d   = 1'b1;
            state_d = S_RD1;
          end else begin
            data_d  = extend_load(fit_shifted, f3_q);
            vld_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RD1: begin
        if (req_q) begin
          if (bus.imem_gnt) req_d = 1'b0;
        end else if (bus.imem_rvalid) begin
          data_d  = extend_load(pair_shifted[DW-1:0], f3_q);
          vld_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.iready) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      maddr_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      mis_q   <= 1'b0;
      lo_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      maddr_q <= maddr_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      mis_q   <= mis_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.oready    = (state_q == S_IDLE);
  assign bus.ovalid    = vld_q;
  assign bus.ordata    = data_q;
  assign bus.oerr      = err_q;
  assign bus.omem_req  = req_q;
  assign bus.omem_addr = maddr_q;
endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: 32-bit split-capable, 32-bit error-on-misalign
// and 64-bit instances sharing one clock and reset.
module tb_load_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  load_unit_if #(.MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(32)) b32  ();
  load_unit_if #(.MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(32)) b32n ();
  load_unit_if #(.MP_DATA_WIDTH(64), .MP_ADDR_WIDTH(32)) b64  ();

  load_unit #(.MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(32), .MP_MISALIGN_EN(1'b1))
    u32  (.iclk(clk), .irst(rst), .bus(b32));
  load_unit #(.MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(32), .MP_MISALIGN_EN(1'b0))
    u32n (.iclk(clk), .irst(rst), .bus(b32n));
  load_unit #(.MP_DATA_WIDTH(64), .MP_ADDR_WIDTH(32), .MP_MISALIGN_EN(1'b1))
    u64  (.iclk(clk), .irst(rst), .bus(b64));

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    b32.ivalid = 0;  b32.iaddr = '0;  b32.ifunct3 = '0;  b32.iready = 0;
    b32.imem_gnt = 0;  b32.imem_rvalid = 0;  b32.imem_rdata = '0;
    b32n.ivalid = 0; b32n.iaddr = '0; b32n.ifunct3 = '0; b32n.iready = 0;
    b32n.imem_gnt = 0; b32n.imem_rvalid = 0; b32n.imem_rdata = '0;
    b64.ivalid = 0;  b64.iaddr = '0;  b64.ifunct3 = '0;  b64.iready = 0;
    b64.imem_gnt = 0;  b64.imem_rvalid = 0;  b64.imem_rdata = '0;
  endtask

  task automatic req32(input logic [31:0] a, input logic [2:0] f3);
    b32.ivalid = 1; b32.iaddr = a; b32.ifunct3 = f3;
    @(negedge clk);
    b32.ivalid = 0;
  endtask

  task automatic req64(input logic [31:0] a, input logic [2:0] f3);
    b64.ivalid = 1; b64.iaddr = a; b64.ifunct3 = f3;
    @(negedge clk);
    b64.ivalid = 0;
  endtask

  // Waits (bounded) for a request, grants it, returns read data next cycle.
  task automatic serve32(input logic [31:0] rd, output logic [31:0] seen, output bit ok);
    ok = 0; seen = '0;
    for (int i = 0; i < 10; i++) begin
      if (b32.omem_req) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) begin
      seen = b32.omem_addr;
      b32.imem_gnt = 1;
      @(negedge clk);
      b32.imem_gnt = 0; b32.imem_rvalid = 1; b32.imem_rdata = rd;
      @(negedge clk);
      b32.imem_rvalid = 0;
    end
  endtask

  task automatic serve64(input logic [63:0] rd, output logic [31:0] seen, output bit ok);
    ok = 0; seen = '0;
    for (int i = 0; i < 10; i++) begin
      if (b64.omem_req) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) begin
      seen = b64.omem_addr;
      b64.imem_gnt = 1;
      @(negedge clk);
      b64.imem_gnt = 0; b64.imem_rvalid = 1; b64.imem_rdata = rd;
      @(negedge clk);
      b64.imem_rvalid = 0;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1;
    @(negedge clk);
    n_cmp++; if (b32.oready !== 1'b1) begin n_bad++; $display("FAIL rst_oready got %b exp 1", b32.oready); end
    n_cmp++; if (b32.ovalid !== 1'b0) begin n_bad++; $display("FAIL rst_ovalid got %b exp 0", b32.ovalid); end
    n_cmp++; if (b32.oerr !== 1'b0) begin n_bad++; $display("FAIL rst_oerr got %b exp 0", b32.oerr); end
    n_cmp++; if (b32.ordata !== 32'h0) begin n_bad++; $display("FAIL rst_ordata got %h exp 0", b32.ordata); end
    n_cmp++; if (b32.omem_req !== 1'b0) begin n_bad++; $display("FAIL rst_omem_req got %b exp 0", b32.omem_req); end
    n_cmp++; if (b32.omem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_omem_addr got %h exp 0", b32.omem_addr); end
    n_cmp++; if (b64.ordata !== 64'h0) begin n_bad++; $display("FAIL rst_ordata64 got %h exp 0", b64.ordata); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_lb_latency();
    req32(32'h0000_0103, 3'b000);
    n_cmp++; if (b32.omem_req !== 1'b1) begin n_bad++; $display("FAIL lb_req got %b exp 1", b32.omem_req); end
    n_cmp++; if (b32.omem_addr !== 32'h0000_0100) begin n_bad++; $display("FAIL lb_addr got %h exp 00000100", b32.omem_addr); end
    n_cmp++; if (b32.oready !== 1'b0) begin n_bad++; $display("FAIL lb_busy got %b exp 0", b32.oready); end
    b32.imem_gnt = 1;
    @(negedge clk);
    b32.imem_gnt = 0;
    n_cmp++; if (b32.omem_req !== 1'b0) begin n_bad++; $display("FAIL lb_req_drop got %b exp 0", b32.omem_req); end
    b32.imem_rvalid = 1; b32.imem_rdata = 32'h80FF_FF00;
    n_cmp++; if (b32.ovalid !== 1'b0) begin n_bad++; $display("FAIL lb_early_ovalid got %b exp 0", b32.ovalid); end
    @(negedge clk);
    b32.imem_rvalid = 0;
    n_cmp++; if (b32.ovalid !== 1'b1) begin n_bad++; $display("FAIL lb_ovalid got %b exp 1", b32.ovalid); end
    n_cmp++; if (b32.ordata !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_data got %h exp ffffff80", b32.ordata); end
    n_cmp++; if (b32.oerr !== 1'b0) begin n_bad++; $display("FAIL lb_err got %b exp 0", b32.oerr); end
    b32.iready = 1;
    @(negedge clk);
    b32.iready = 0;
    n_cmp++; if (b32.ovalid !== 1'b0 || b32.oready !== 1'b1) begin n_bad++; $display("FAIL lb_release got ovalid=%b oready=%b exp 0/1", b32.ovalid, b32.oready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr_t [5] = '{32'h102, 32'h103, 32'h101, 32'h104, 32'h100};
    logic [2:0]  f3_t   [5] = '{3'b001, 3'b100, 3'b101, 3'b010, 3'b000};
    logic [31:0] rd_t   [5] = '{32'h80FF_FF00, 32'h80FF_FF00, 32'h80FF_FF00, 32'h80FF_FF00, 32'h0000_007F};
    logic [31:0] ea_t   [5] = '{32'h100, 32'h100, 32'h100, 32'h104, 32'h100};
    logic [31:0] ed_t   [5] = '{32'hFFFF_80FF, 32'h0000_0080, 32'h0000_FFFF, 32'h80FF_FF00, 32'h0000_007F};
    logic [31:0] seen;
    bit ok;
    for (int k = 0; k < 5; k++) begin
      req32(addr_t[k], f3_t[k]);
      serve32(rd_t[k], seen, ok);
      n_cmp++; if (!ok || seen !== ea_t[k]) begin n_bad++; $display("FAIL b2b_addr[%0d] got %h ok=%0d exp %h", k, seen, ok, ea_t[k]); end
      n_cmp++; if (b32.ovalid !== 1'b1 || b32.ordata !== ed_t[k]) begin n_bad++; $display("FAIL b2b_data[%0d] got v=%b %h exp 1 %h", k, b32.ovalid, b32.ordata, ed_t[k]); end
      b32.iready = 1;
      @(negedge clk);
      b32.iready = 0;
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] s0, s1;
    bit ok0, ok1;
    req32(32'h0000_0203, 3'b101);
    serve32(32'hAB00_0000, s0, ok0);
    n_cmp++; if (!ok0 || s0 !== 32'h200) begin n_bad++; $display("FAIL mis_addr0 got %h ok=%0d exp 00000200", s0, ok0); end
    n_cmp++; if (b32.ovalid !== 1'b0) begin n_bad++; $display("FAIL mis_mid_ovalid got %b exp 0", b32.ovalid); end
    serve32(32'h0000_00CD, s1, ok1);
    n_cmp++; if (!ok1 || s1 !== 32'h204) begin n_bad++; $display("FAIL mis_addr1 got %h ok=%0d exp 00000204", s1, ok1); end
    n_cmp++; if (b32.ovalid !== 1'b1 || b32.ordata !== 32'h0000_CDAB) begin n_bad++; $display("FAIL mis_data got v=%b %h exp 1 0000cdab", b32.ovalid, b32.ordata); end
    b32.iready = 1; @(negedge clk); b32.iready = 0;
    // Word straddling the top of the address space wraps to 0.
    req32(32'hFFFF_FFFE, 3'b010);
    serve32(32'h1234_5678, s0, ok0);
    serve32(32'h9ABC_DEF0, s1, ok1);
    n_cmp++; if (!ok0 || !ok1 || s0 !== 32'hFFFF_FFFC || s1 !== 32'h0) begin n_bad++; $display("FAIL wrap_addr got %h %h exp fffffffc 00000000", s0, s1); end
    n_cmp++; if (b32.ordata !== 32'hDEF0_1234) begin n_bad++; $display("FAIL wrap_data got %h exp def01234", b32.ordata); end
    b32.iready = 1; @(negedge clk); b32.iready = 0;
  endtask

  task automatic test_misalign_err();
    bit saw_req = 0;
    b32n.ivalid = 1; b32n.iaddr = 32'h0000_0202; b32n.ifunct3 = 3'b010;
    @(negedge clk);
    b32n.ivalid = 0;
    saw_req = b32n.omem_req;
    n_cmp++; if (b32n.ovalid !== 1'b1 || b32n.oerr !== 1'b1) begin n_bad++; $display("FAIL mae_flags got v=%b e=%b exp 1 1", b32n.ovalid, b32n.oerr); end
    n_cmp++; if (b32n.ordata !== 32'h0) begin n_bad++; $display("FAIL mae_data got %h exp 0", b32n.ordata); end
    @(negedge clk);
    saw_req = saw_req | b32n.omem_req;
    n_cmp++; if (saw_req !== 1'b0) begin n_bad++; $display("FAIL mae_noreq got %b exp 0", saw_req); end
    b32n.iready = 1; @(negedge clk); b32n.iready = 0;
    n_cmp++; if (b32n.ovalid !== 1'b0 || b32n.oready !== 1'b1) begin n_bad++; $display("FAIL mae_release got v=%b r=%b exp 0 1", b32n.ovalid, b32n.oready); end
  endtask

  task automatic test_w64();
    logic [31:0] s;
    bit ok;
    req64(32'h0000_1000, 3'b011);
    serve64(64'h8000_0000_0000_0001, s, ok);
    n_cmp++; if (!ok || s !== 32'h1000) begin n_bad++; $display("FAIL ld_addr got %h exp 00001000", s); end
    n_cmp++; if (b64.ordata !== 64'h8000_0000_0000_0001) begin n_bad++; $display("FAIL ld_data got %h exp 8000000000000001", b64.ordata); end
    b64.iready = 1; @(negedge clk); b64.iready = 0;
    req64(32'h0000_1004, 3'b110);
    serve64(64'h8000_0000_0000_0001, s, ok);
    n_cmp++; if (!ok || s !== 32'h1000) begin n_bad++; $display("FAIL lwu_addr got %h exp 00001000", s); end
    n_cmp++; if (b64.ordata !== 64'h0000_0000_8000_0000) begin n_bad++; $display("FAIL lwu_data got %h exp 0000000080000000", b64.ordata); end
    b64.iready = 1; @(negedge clk); b64.iready = 0;
    req64(32'h0000_1004, 3'b010);
    serve64(64'h8000_0000_0000_0001, s, ok);
    n_cmp++; if (b64.ordata !== 64'hFFFF_FFFF_8000_0000) begin n_bad++; $display("FAIL lw64_data got %h exp ffffffff80000000", b64.ordata); end
    b64.iready = 1; @(negedge clk); b64.iready = 0;
  endtask

  task automatic test_illegal();
    bit held = 1;
    bit saw_req = 0;
    req32(32'h0000_0040, 3'b111);
    n_cmp++; if (b32.ovalid !== 1'b1 || b32.oerr !== 1'b1 || b32.ordata !== 32'h0) begin n_bad++; $display("FAIL ill_resp got v=%b e=%b d=%h exp 1 1 0", b32.ovalid, b32.oerr, b32.ordata); end
    // A request offered during the stall must not be taken.
    b32.ivalid = 1; b32.iaddr = 32'h80; b32.ifunct3 = 3'b010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      held = held & b32.ovalid;
      saw_req = saw_req | b32.omem_req;
    end
    b32.ivalid = 0;
    n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL ill_stall got %b exp 1", held); end
    n_cmp++; if (saw_req !== 1'b0) begin n_bad++; $display("FAIL ill_noreq got %b exp 0", saw_req); end
    b32.iready = 1; @(negedge clk); b32.iready = 0;
    @(negedge clk);
    n_cmp++; if (b32.omem_req !== 1'b0 || b32.ovalid !== 1'b0) begin n_bad++; $display("FAIL ill_ignored got req=%b v=%b exp 0 0", b32.omem_req, b32.ovalid); end
    req32(32'h0000_0040, 3'b011);
    n_cmp++; if (b32.ovalid !== 1'b1 || b32.oerr !== 1'b1) begin n_bad++; $display("FAIL ill_ld32 got v=%b e=%b exp 1 1", b32.ovalid, b32.oerr); end
    b32.iready = 1; @(negedge clk); b32.iready = 0;
  endtask

  task automatic test_reset_mid();
    bit ok = 0;
    bit late_v = 0;
    req32(32'h0000_0300, 3'b010);
    for (int i = 0; i < 10; i++) begin
      if (b32.omem_req) begin ok = 1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_req got 0 exp 1"); end
    b32.imem_gnt = 1;
    @(negedge clk);
    b32.imem_gnt = 0;
    rst = 1;
    #1;
    n_cmp++; if (b32.oready !== 1'b1 || b32.omem_req !== 1'b0 || b32.ovalid !== 1'b0) begin n_bad++; $display("FAIL rmid_abort got r=%b q=%b v=%b exp 1 0 0", b32.oready, b32.omem_req, b32.ovalid); end
    @(negedge clk);
    rst = 0;
    b32.imem_rvalid = 1; b32.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    b32.imem_rvalid = 0;
    late_v = b32.ovalid;
    @(negedge clk);
    late_v = late_v | b32.ovalid;
    n_cmp++; if (late_v !== 1'b0 || b32.oready !== 1'b1) begin n_bad++; $display("FAIL rmid_late got v=%b r=%b exp 0 1", late_v, b32.oready); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_lb_latency();
    test_back_to_back();
    test_misaligned();
    test_misalign_err();
    test_w64();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
